// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 on load, per-round C/D rotation and PC-2 subkey generation,
// stepped by the DES control FSM in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_key,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        en_key_schedule,
    input  logic [4:0]  round_count,
    output logic        key_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [4:0]  subkey_round,
    output logic        sched_error
);

    // Tables list DES bit numbers (1 = MSB of the source vector).
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [27:0] rotl(input logic [27:0] v, input logic [1:0] k);
        case (k)
            2'd1:    rotl = {v[26:0], v[27]};
            2'd2:    rotl = {v[25:0], v[27:26]};
            default: rotl = v;
        endcase
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] k);
        case (k)
            2'd1:    rotr = {v[0], v[27:1]};
            2'd2:    rotr = {v[1:0], v[27:2]};
            default: rotr = v;
        endcase
    endfunction

    logic [55:0] cd_q, cd_d;
    logic [4:0]  step_q, step_d;
    logic        mode_q, mode_d;
    logic        loaded_q, loaded_d;
    logic [47:0] subkey_q, subkey_d;
    logic        valid_q, valid_d;
    logic [4:0]  round_q, round_d;
    logic        err_q, err_d;

    logic [55:0] pc1_key;
    logic [55:0] cd_rot;
    logic [55:0] cd_wrap;
    logic [47:0] round_key;
    logic [4:0]  step_n;
    logic        single_shift;
    logic [1:0]  rot_amt;
    logic        load_ok;
    logic        step_ok;

    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
        localparam int SRC = 64 - PC1_TBL[gi];
        assign pc1_key[55-gi] = key_in[SRC];
    end

    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
        localparam int SRC = 56 - PC2_TBL[gi];
        assign round_key[47-gi] = cd_rot[SRC];
    end

    assign step_n       = step_q + 5'd1;
    assign single_shift = (step_n == 5'd1) || (step_n == 5'd2) ||
                          (step_n == 5'd9) || (step_n == 5'd16);

    always_comb begin
        rot_amt = single_shift ? 2'd1 : 2'd2;
        if (mode_q && step_n == 5'd1) begin
            rot_amt = 2'd0;
        end
    end

    assign cd_rot = mode_q ? {rotr(cd_q[55:28], rot_amt), rotr(cd_q[27:0], rot_amt)}
                           : {rotl(cd_q[55:28], rot_amt), rotl(cd_q[27:0], rot_amt)};

    // Decrypt rotations only total 27 over a block; one more right shift
    // at the wrap restores the PC-1 value so the next block needs no reload.
    assign cd_wrap = {rotr(cd_rot[55:28], 2'd1), rotr(cd_rot[27:0], 2'd1)};

    assign load_ok = load_key && (step_q == 5'd0);
    assign step_ok = en_key_schedule && loaded_q && !load_key && (round_count == step_q);

    always_comb begin
        cd_d     = cd_q;
        step_d   = step_q;
        mode_d   = mode_q;
        loaded_d = loaded_q;
        subkey_d = subkey_q;
        valid_d  = valid_q;
        round_d  = round_q;
        err_d    = (load_key && step_q != 5'd0) || (en_key_schedule && !step_ok);
        if (load_ok) begin
            cd_d     = pc1_key;
            mode_d   = decrypt;
            loaded_d = 1'b1;
            valid_d  = 1'b0;
            round_d  = 5'd0;
        end else if (step_ok) begin
            cd_d     = (mode_q && step_n == 5'd16) ? cd_wrap : cd_rot;
            step_d   = (step_n == 5'd16) ? 5'd0 : step_n;
            subkey_d = round_key;
            valid_d  = 1'b1;
            round_d  = mode_q ? (5'd17 - step_n) : step_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cd_q     <= '0;
            step_q   <= '0;
            mode_q   <= 1'b0;
            loaded_q <= 1'b0;
            subkey_q <= '0;
            valid_q  <= 1'b0;
            round_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            cd_q     <= cd_d;
            step_q   <= step_d;
            mode_q   <= mode_d;
            loaded_q <= loaded_d;
            subkey_q <= subkey_d;
            valid_q  <= valid_d;
            round_q  <= round_d;
            err_q    <= err_d;
        end
    end

    assign key_ready    = loaded_q;
    assign subkey       = subkey_q;
    assign subkey_valid = valid_q;
    assign subkey_round = round_q;
    assign sched_error  = err_q;

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset; synchronous, active-low, sampled on rising clk edge.
REQ-003 load_key  input  1  single-cycle request to capture key_in and decrypt.
REQ-004 key_in  input  64  DES key; key_in[63] = DES bit 1; parity bits 8,16,...,64 ignored.
REQ-005 decrypt  input  1  0 = encrypt order K1..K16, 1 = decrypt order K16..K1; sampled only on accepted load.
REQ-006 en_key_schedule  input  1  step request from the DES control FSM, one cycle per round.
REQ-007 round_count  input  5  control FSM round counter; equals number of completed steps (0..15) at each step.
REQ-008 key_ready  output  1  a key is loaded and the schedule is usable.
REQ-009 subkey  output  48  current round subkey after PC-2; subkey[47] = PC-2 output bit 1.
REQ-010 subkey_valid  output  1  subkey holds a valid round key.
REQ-011 subkey_round  output  5  round tag of subkey, 1..16 (encrypt) or 16..1 (decrypt).
REQ-012 sched_error  output  1  one-cycle pulse on a rejected request.

Function
REQ-013 Internal state: C, D (28 bits each), step counter 0..16, mode bit, loaded flag.
REQ-014 Load accepted only when step counter = 0: C/D <= PC-1(key_in); mode <= decrypt; loaded <= 1; subkey_valid <= 0; subkey_round <= 0.
REQ-015 load_key with step counter 1..15: ignored; sched_error pulses next cycle; C/D, step counter, and subkey are unchanged.
REQ-016 Step accepted when loaded = 1, load_key = 0, and round_count = step counter.
REQ-017 Step with loaded = 0, with round_count mismatch, or in the same cycle as load_key: no state change; sched_error pulses next cycle.
REQ-018 If load_key and en_key_schedule are both asserted with step counter = 0, the load is performed and the step is rejected per REQ-017.
REQ-019 Encrypt step n (n = step counter + 1): rotate C and D left by 1 for n = 1, 2, 9, 16; otherwise rotate left by 2.
REQ-020 Decrypt step n: no rotation for n = 1; rotate right by 1 for n = 2, 9, 16; otherwise rotate right by 2.
REQ-021 subkey <= PC-2 of the rotated {C,D}, registered one cycle after the accepted step. subkey_valid <= 1. subkey_round <= n (encrypt) or 17-n (decrypt).
REQ-022 subkey, subkey_valid, and subkey_round hold until the next accepted step, an accepted load, or reset, so the value stays stable through the expansion and key-mixing cycles.
REQ-023 Step counter increments per accepted step. After step 16 it wraps to 0, and C/D equal the PC-1 value again (total rotation 28).
REQ-024 After the wrap, key_ready stays 1 and the same key serves the next block without a reload.
REQ-025 key_ready = loaded flag, registered; it falls only on reset.
REQ-026 All outputs are registered; there is no combinational path from inputs to outputs.

Reset
REQ-027 On rst_n = 0 at a clock edge: C = D = 0; step counter = 0; loaded = 0; mode = 0; key_ready = 0; subkey = 0; subkey_valid = 0; subkey_round = 0; sched_error = 0.
REQ-028 Reset in the middle of a schedule abandons it; a fresh load is required before any step is accepted.

Verification
REQ-029 Load key 133457799BBCDFF1 with decrypt = 0, then step with round_count = 0 -> subkey = 1B02EFFC7072, subkey_round = 1, subkey_valid = 1 on the following cycle.
REQ-030 Continue the REQ-029 schedule for 16 steps -> 16th subkey = CB3D8B0E17F5 with subkey_round = 16; step counter = 0; key_ready = 1; internal C/D equal their post-load values.
REQ-031 Same key with decrypt = 1, first step -> subkey = CB3D8B0E17F5 with subkey_round = 16; 16th step -> 1B02EFFC7072 with subkey_round = 1.
REQ-032 en_key_schedule before any load, and a step with round_count = 3 when the counter = 2 -> sched_error pulses for one cycle; subkey and the counter are unchanged.
REQ-033 load_key after 5 steps -> ignored with a sched_error pulse. load_key and en_key_schedule in the same cycle at counter 0 -> load taken, step rejected with sched_error.
REQ-034 Assert rst_n = 0 after 7 steps -> all outputs equal the REQ-027 values next cycle; a subsequent step without a load -> sched_error.
